// File: rtl/num_entry_pkg.sv
// rtl/num_entry_pkg.sv - shared key codes, FSM encodings and size defaults for num_entry
package num_entry_pkg;

    // Default geometry: 4 decimal digits converted into a 16-bit signed operand
    localparam int NDIG_DEF = 4;
    localparam int W_DEF    = 16;

    // Non-digit key codes; 0xD and 0xF are deliberately left unassigned (ignored)
    localparam logic [3:0] KEY_SIGN = 4'hA;
    localparam logic [3:0] KEY_BKSP = 4'hB;
    localparam logic [3:0] KEY_CLR  = 4'hC;
    localparam logic [3:0] KEY_ENT  = 4'hE;

    // Controller states
    localparam logic [1:0] ST_ENTRY = 2'd0;
    localparam logic [1:0] ST_CONV  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Codes 0..9 are decimal digits
    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/num_entry_bcd_mac10.sv
// rtl/num_entry_bcd_mac10.sv - combinational acc*10 + digit step for decimal-to-binary conversion
module bcd_mac10 #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_acc,
    input  logic [3:0]   i_digit,
    output logic [W-1:0] o_result
);

    logic [W-1:0] w_digit_ext;

    // x10 as x8 + x2 keeps this a pair of shifts and adders; result wraps to W bits
    always_comb begin
        w_digit_ext = {{(W-4){1'b0}}, i_digit};
        o_result    = (i_acc << 3) + (i_acc << 1) + w_digit_ext;
    end

endmodule

// File: rtl/num_entry.sv
// rtl/num_entry.sv - keypad digit entry with sequential BCD-to-binary conversion on enter
module num_entry
    import num_entry_pkg::*;
#(
    parameter int NDIG = NDIG_DEF,
    parameter int W    = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    output logic         ready,
    output logic [3:0]   thd,
    output logic [3:0]   hud,
    output logic [3:0]   ten,
    output logic [3:0]   one,
    output logic         neg,
    output logic [2:0]   ndig,
    output logic         out_valid,
    output logic [W-1:0] out_value
);

    localparam int IW = $clog2(NDIG);

    // r_dig[0] is the ones digit, r_dig[NDIG-1] the most significant
    logic [3:0]    r_dig [NDIG];
    logic [2:0]    r_ndig;
    logic          r_neg;
    logic [1:0]    r_state;
    logic [W-1:0]  r_acc;
    logic [IW-1:0] r_idx;
    logic          r_out_valid;
    logic [W-1:0]  r_out_value;

    logic          w_ready;
    logic          w_accept;
    logic [3:0]    w_cur_digit;
    logic [W-1:0]  w_mac;
    logic [W-1:0]  w_result;

    // Keys are only blocked while the conversion loop owns the accumulator
    always_comb begin
        w_ready     = (r_state != ST_CONV);
        w_accept    = key_valid && w_ready;
        // Conversion walks MSB first: idx 0 selects the top digit
        w_cur_digit = r_dig[IW'(NDIG-1) - r_idx];
        // Two's-complement negate; a zero magnitude naturally stays zero
        w_result    = r_neg ? (~w_mac + {{(W-1){1'b0}}, 1'b1}) : w_mac;
    end

    bcd_mac10 #(
        .W(W)
    ) u_mac (
        .i_acc    (r_acc),
        .i_digit  (w_cur_digit),
        .o_result (w_mac)
    );

    // Entry editing, conversion sequencing and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ENTRY;
            for (int i = 0; i < NDIG; i++) r_dig[i] <= 4'd0;
            r_ndig      <= 3'd0;
            r_neg       <= 1'b0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_value <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_CONV: begin
                    r_acc <= w_mac;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == IW'(NDIG-1)) begin
                        // Publish the result and hand back a blank entry for the DONE cycle
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_out_value <= w_result;
                        for (int i = 0; i < NDIG; i++) r_dig[i] <= 4'd0;
                        r_ndig      <= 3'd0;
                        r_neg       <= 1'b0;
                    end
                end
                default: begin
                    // ENTRY and DONE behave identically for keys; DONE only lasts one cycle
                    r_state <= ST_ENTRY;
                    if (w_accept) begin
                        if (is_digit(key_code)) begin
                            if ((r_ndig != 3'(NDIG)) && !((r_ndig == 3'd0) && (key_code == 4'd0))) begin
                                for (int i = NDIG-1; i > 0; i--) r_dig[i] <= r_dig[i-1];
                                r_dig[0] <= key_code;
                                r_ndig   <= r_ndig + 3'd1;
                            end
                        end else begin
                            case (key_code)
                                KEY_SIGN: r_neg <= ~r_neg;
                                KEY_BKSP: begin
                                    if (r_ndig != 3'd0) begin
                                        for (int i = 0; i < NDIG-1; i++) r_dig[i] <= r_dig[i+1];
                                        r_dig[NDIG-1] <= 4'd0;
                                        r_ndig        <= r_ndig - 3'd1;
                                    end
                                end
                                KEY_CLR: begin
                                    for (int i = 0; i < NDIG; i++) r_dig[i] <= 4'd0;
                                    r_ndig <= 3'd0;
                                    r_neg  <= 1'b0;
                                end
                                KEY_ENT: begin
                                    r_acc   <= '0;
                                    r_idx   <= '0;
                                    r_state <= ST_CONV;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign ready     = w_ready;
    assign thd       = r_dig[NDIG-1];
    assign hud       = r_dig[NDIG-2];
    assign ten       = r_dig[NDIG-3];
    assign one       = r_dig[NDIG-4];
    assign neg       = r_neg;
    assign ndig      = r_ndig;
    assign out_valid = r_out_valid;
    assign out_value = r_out_value;

endmodule

// File: doc/num_entry.md
Name: num_entry

Overview:
- Sequential keypad digit-entry and decimal-to-binary converter for the calculator datapath. It is the inverse of the binary-to-digit splitter.
- Accepts key codes one per handshake and builds a signed, right-justified 4-digit BCD entry, which it also echoes for display.
- On an enter key it iteratively converts the BCD entry (acc*10 + digit, MSB first) into a 16-bit two's-complement operand for calc_mul/calc_div.

Parameters:
- NDIG, 4, number of decimal digits held; the conversion runs for NDIG cycles.
- W, 16, width of out_value; must satisfy 2^(W-1) > 10^NDIG - 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- key_valid  in  1  key strobe; accepted on an edge where key_valid && ready
- key_code  in  4  0-9 digit, 0xA sign toggle, 0xB backspace, 0xC clear, 0xE enter; 0xD and 0xF ignored
- ready  out  1  high when a key can be accepted
- thd  out  4  entry thousands digit (BCD)
- hud  out  4  entry hundreds digit
- ten  out  4  entry tens digit
- one  out  4  entry ones digit
- neg  out  1  entry sign, 1 = negative
- ndig  out  3  count of digits entered, 0..NDIG
- out_valid  out  1  one-cycle pulse when out_value is updated
- out_value  out  W  converted signed result, held until the next conversion

Behaviour:
- Reset: state ENTRY, all digits 0, ndig=0, neg=0, out_valid=0, out_value=0, ready=1.
- Reset has priority over everything, including mid-conversion; any conversion in progress is discarded.
- FSM states: ENTRY, CONV, DONE.
  - ready=1 in ENTRY and DONE; ready=0 in CONV.
- ENTRY, accepted digit d:
  - if ndig==NDIG: ignored (full)
  - else if ndig==0 and d==0: ignored (no leading zeros)
  - else: digits shift left (thd<=hud, hud<=ten, ten<=one, one<=d), ndig+1
- ENTRY, sign key: neg<=~neg, allowed at any ndig.
- ENTRY, backspace:
  - if ndig==0: no-op
  - else: one<=ten, ten<=hud, hud<=thd, thd<=0, ndig-1; neg is unchanged
- ENTRY, clear: digits=0, ndig=0, neg=0. out_value is not affected.
- ENTRY, enter: acc<=0, idx<=0, go to CONV.
- CONV: exactly NDIG cycles; each cycle acc<=acc*10 + digit[idx], visiting thd, hud, ten, one in that order.
  - Multiply by 10 is implemented as (acc<<3)+(acc<<1), truncated to W bits.
  - Keys are not accepted; key_valid is ignored.
  - Entry registers hold their value during CONV.
- DONE is entered after the last CONV cycle and lasts 1 cycle:
  - out_valid=1
  - out_value = neg ? -acc : acc; if acc==0 the result is 0 (no -0)
  - digits, ndig and neg are cleared
- DONE next state: ENTRY.
  - A key presented in DONE is accepted and processed as in ENTRY against the cleared entry.
  - Example: a digit key in DONE starts a new number.
- Latency: enter accepted at edge E0 → CONV at edges E1..E4 → out_valid high in the cycle after E4 (5 cycles after acceptance for NDIG=4).
- Enter with ndig==0 gives out_value=0 and out_valid pulses.
- Maximum magnitude is 9999 → 0x270F; -9999 → 0xD8F1.

Decomposition:
- Shared package: key-code constants (KEY_SIGN=0xA, KEY_BKSP=0xB, KEY_CLR=0xC, KEY_ENT=0xE), FSM state encodings, NDIG/W defaults.
- One sub-module is natural: bcd_mac10, combinational acc*10 + digit (W-bit in, 4-bit digit in, W-bit out). It is reusable by num_join.

Test Plan:
- Keys 1,2,3,4,enter → out_valid 5 cycles after enter, out_value=0x04D2 (1234); display shows 1,2,3,4 before enter and 0,0,0,0 with ndig=0 after DONE.
- Keys 0,0,7,sign,enter → ndig=1, one=7, neg=1, out_value=0xFFF9 (-7); key_valid held high during CONV is ignored and ready=0 for 4 cycles.
- Keys 9,9,9,9,5,enter → fifth digit ignored, ndig stays 4, out_value=0x270F; add a sign toggle before enter → 0xD8F1.
- Keys 5,6,bksp,bksp,bksp,8,enter → extra bksp is a no-op, out_value=8; keys sign,clear,enter → out_value=0, out_valid pulses, neg=0.
- Enter then rst asserted on the 2nd CONV cycle → next cycle all outputs are at reset values, out_value stays 0, and no out_valid pulse occurs.
- Back-to-back: key 3 presented in the DONE cycle of a previous 42 conversion → out_value=42, and the new entry shows one=3, ndig=1.
